// File: rtl/wb_simple_master.sv
// wb_simple_master: Wishbone classic single-transfer master fed by a valid/ready command port.
// Defining WB_MASTER_TIMEOUT_EN adds a bus timeout (status 11) after TIMEOUT_CYCLES silent cycles.
module wb_simple_master #(
  parameter int AW             = 32,
  parameter int DW             = 8,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [DW-1:0] cmd_dat,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_status,
  output logic [DW-1:0] rsp_dat,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);
  // state      | meaning
  // IDLE       | waiting for a command, cmd_ready high
  // BUS        | cyc/stb asserted, waiting for a termination
  // RETRY_WAIT | one idle bus cycle before re-issuing a retried access
  // RESP       | rsp_valid high until rsp_ready
  typedef enum logic [1:0] {IDLE, BUS, RETRY_WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] adr_nx;
  logic [DW-1:0] dat_nx, rdat_nx;
  logic          we_nx, cyc_nx, rsp_valid_nx;
  logic [1:0]    status_nx;
  logic [3:0]    retry_cnt, retry_cnt_nx;
  logic          tmo_hit;

  assign cmd_ready = (state == IDLE) & ~wb_rst;
  assign wb_stb_o  = wb_cyc_o;
  assign wb_cti_o  = 3'b000;
  assign wb_bte_o  = 2'b00;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt;

  // Held at zero outside BUS, so every BUS entry (including re-issues) starts a fresh count.
  always_ff @(posedge wb_clk) begin
    if (wb_rst || state != BUS) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    adr_nx       = wb_adr_o;
    dat_nx       = wb_dat_o;
    we_nx        = wb_we_o;
    cyc_nx       = wb_cyc_o;
    rsp_valid_nx = rsp_valid;
    status_nx    = rsp_status;
    rdat_nx      = rsp_dat;
    retry_cnt_nx = retry_cnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          adr_nx   = cmd_adr;
          dat_nx   = cmd_dat;
          we_nx    = cmd_we;
          cyc_nx   = 1'b1;
          state_nx = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          cyc_nx       = 1'b0;
          status_nx    = 2'b01;
          rdat_nx      = '0;
          rsp_valid_nx = 1'b1;
          state_nx     = RESP;
        end else if (wb_rty_i) begin
          cyc_nx = 1'b0;
          if (retry_cnt < 4'(MAX_RETRY)) begin
            retry_cnt_nx = retry_cnt + 4'd1;
            state_nx     = RETRY_WAIT;
          end else begin
            status_nx    = 2'b10;
            rdat_nx      = '0;
            rsp_valid_nx = 1'b1;
            state_nx     = RESP;
          end
        end else if (wb_ack_i) begin
          cyc_nx       = 1'b0;
          status_nx    = 2'b00;
          rdat_nx      = wb_we_o ? '0 : wb_dat_i;
          rsp_valid_nx = 1'b1;
          state_nx     = RESP;
        end else if (tmo_hit) begin
          cyc_nx       = 1'b0;
          status_nx    = 2'b11;
          rdat_nx      = '0;
          rsp_valid_nx = 1'b1;
          state_nx     = RESP;
        end
      end
      RETRY_WAIT: begin
        cyc_nx   = 1'b1;
        state_nx = BUS;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          retry_cnt_nx = '0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state      <= IDLE;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= 2'b00;
      rsp_dat    <= '0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_nx;
      wb_adr_o   <= adr_nx;
      wb_dat_o   <= dat_nx;
      wb_we_o    <= we_nx;
      wb_cyc_o   <= cyc_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_status <= status_nx;
      rsp_dat    <= rdat_nx;
      retry_cnt  <= retry_cnt_nx;
    end
  end
endmodule
